// File: rtl/idct2_seq_if.sv
// Handshake bundle for idct2_seq: coefficient vector in, sample vector out.
// Ports: in_valid/in_ready/N/coef (input side), out_valid/out_ready/Y (output side).
interface idct2_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   N;
  logic [511:0] coef;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] Y;

  modport master (
    output in_valid, N, coef, out_ready,
    input  in_ready, out_valid, Y
  );

  modport slave (
    input  in_valid, N, coef, out_ready,
    output in_ready, out_valid, Y
  );
endinterface

// File: rtl/idct2_seq.sv
// Sequential 4/8/16/32-point inverse DCT-II with a single MAC unit.
// Ports: clk, rst_n (async, active-low), bus (idct2_seq_if.slave).
module idct2_seq #(
  parameter int SHIFT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  idct2_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic signed [30:0] RND = 31'sd1 <<< (SHIFT - 1);

  state_t state, state_nx;

  logic [1:0]         nsz;
  logic [511:0]       xr;
  logic [4:0]         k, n, lm1;
  logic signed [29:0] acc, sum;
  logic               last_k, last;

  logic [6:0]         ks, odd, m, mf, gv;
  logic [5:0]         gi;
  logic               neg;
  logic signed [7:0]  t;
  logic signed [15:0] xk;
  logic signed [23:0] prod;
  logic signed [30:0] rnd, shd;
  logic [15:0]        ysat;

  function automatic logic [6:0] gtab(input logic [5:0] i);
    unique case (i)
      6'd0:  gtab = 7'd64;
      6'd1:  gtab = 7'd90;
      6'd2:  gtab = 7'd90;
      6'd3:  gtab = 7'd90;
      6'd4:  gtab = 7'd89;
      6'd5:  gtab = 7'd88;
      6'd6:  gtab = 7'd87;
      6'd7:  gtab = 7'd85;
      6'd8:  gtab = 7'd83;
      6'd9:  gtab = 7'd82;
      6'd10: gtab = 7'd80;
      6'd11: gtab = 7'd78;
      6'd12: gtab = 7'd75;
      6'd13: gtab = 7'd73;
      6'd14: gtab = 7'd70;
      6'd15: gtab = 7'd67;
      6'd16: gtab = 7'd64;
      6'd17: gtab = 7'd61;
      6'd18: gtab = 7'd57;
      6'd19: gtab = 7'd54;
      6'd20: gtab = 7'd50;
      6'd21: gtab = 7'd46;
      6'd22: gtab = 7'd43;
      6'd23: gtab = 7'd38;
      6'd24: gtab = 7'd36;
      6'd25: gtab = 7'd31;
      6'd26: gtab = 7'd25;
      6'd27: gtab = 7'd22;
      6'd28: gtab = 7'd18;
      6'd29: gtab = 7'd13;
      6'd30: gtab = 7'd9;
      6'd31: gtab = 7'd4;
      default: gtab = 7'd0;
    endcase
  endfunction

  always_comb begin
    lm1    = 5'((6'd4 << nsz) - 6'd1);
    last_k = (k == lm1);
    last   = last_k && (n == lm1);
  end

  // k*step is k shifted by log2(32/L); only the low 7 bits matter mod 128
  always_comb begin
    ks   = 7'({3'b000, k} << (2'd3 - nsz));
    odd  = {1'b0, n, 1'b1};
    m    = 7'(ks * odd);
    mf   = (m > 7'd64) ? 7'(8'd128 - {1'b0, m}) : m;
    neg  = (mf > 7'd32);
    gi   = neg ? 6'(7'd64 - mf) : mf[5:0];
    gv   = gtab(gi);
    t    = neg ? -signed'({1'b0, gv}) : signed'({1'b0, gv});
    xk   = signed'(xr[16*k +: 16]);
    prod = xk * t;
    sum  = acc + {{6{prod[23]}}, prod};
    rnd  = signed'({sum[29], sum}) + RND;
    shd  = rnd >>> SHIFT;
    if (shd > 31'sd32767)
      ysat = 16'h7fff;
    else if (shd < -31'sd32768)
      ysat = 16'h8000;
    else
      ysat = shd[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nx = CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nsz    <= '0;
      xr     <= '0;
      k      <= '0;
      n      <= '0;
      acc    <= '0;
      bus.Y  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            nsz   <= bus.N;
            xr    <= bus.coef;
            bus.Y <= '0;
            k     <= '0;
            n     <= '0;
            acc   <= '0;
          end
        end
        CALC: begin
          if (last_k) begin
            bus.Y[16*n +: 16] <= ysat;
            acc <= '0;
            k   <= '0;
            n   <= n + 5'd1;
          end else begin
            acc <= sum;
            k   <= k + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
